pending_flag_drain: RTL and testbench
=====================================

// Module: pending_flag_drain
// PURPOSE
//  Collects 8-bit event pulses into a sticky pending register by bitwise OR.
//  Drains that register one flag at a time as a bit index, over a valid/ready handshake.
//  Drained flags are cleared; selection is round-robin.
//  Sits between event sources (OR-style set side) and a consumer/CPU (read-and-clear side).
// PARAMETERS
//  WIDTH  8  number of flag bits
//  IDX_W  3  index width; must equal clog2(WIDTH)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  set_in     in   WIDTH  event pulses; each 1 bit ORs into pend
//  clr_we     in   1      qualifies clr_mask for this cycle
//  clr_mask   in   WIDTH  write-1-to-clear mask for pend and lost
//  out_valid  out  1      out_idx holds a drained flag
//  out_idx    out  IDX_W  index of drained flag
//  out_ready  in   1      consumer accepts out_idx this cycle
//  pend_o     out  WIDTH  current pending register
//  lost_o     out  WIDTH  sticky: event arrived while its bit was already pending
//  any_pend   out  1      |pend
// BEHAVIOUR
//  Reset:
//   - Async, active-high.
//   - pend, lost, out_valid, out_idx and ptr all go to 0 immediately.
//   - Reset held mid-handshake drops out_valid; the presented index is discarded.
//  Pending register, computed each cycle:
//   - pend_nxt = (pend & ~(clr_we ? clr_mask : 0) & ~load_bit) | set_in
//   - Set wins over clear and over load on the same bit in the same cycle.
//   - load_bit is one-hot of the index moved to the output stage this cycle, else 0.
//  Lost register:
//   - lost[i] <= 1 when set_in[i] & pend[i] & ~load_bit[i].
//   - lost[i] <= 0 when clr_we & clr_mask[i], unless it is set the same cycle (set wins).
//  Output stage (single entry):
//   - Stage is free when !out_valid, or when out_valid & out_ready.
//   - If free and pend != 0: load. out_idx <= first set bit of pend searching ptr, ptr+1, ... wrapping at WIDTH-1 -> 0.
//   - On load: out_valid <= 1, that bit is cleared in pend, ptr <= (idx+1) mod WIDTH.
//   - If free and pend == 0: out_valid <= 0, ptr unchanged.
//   - While out_valid & !out_ready: out_idx, out_valid and ptr hold stable.
//   - clr_mask does not affect an index already in the output stage.
//  Throughput and latency:
//   - Back-to-back pops deliver 1 index/cycle with out_ready held high.
//   - Latency: set_in at edge N -> pend bit at N+1 -> out_valid at N+2 (stage free).
//  Width rules:
//   - ptr and out_idx are IDX_W bits; wrap is mod WIDTH.
//   - No X on outputs after reset.
// TESTING
//  T1 reset: assert rst async mid-cycle with out_valid=1 -> all outputs 0 before next edge.
//  T2 drain: set_in=8'h24 one cycle, out_ready=1 -> out_idx 2 then 5 on consecutive valid cycles; pend_o ends 8'h00; ptr=6.
//  T3 round-robin: after T2 (ptr=6), set_in=8'h81 -> out_idx 7 first, then 0; ptr=1.
//  T4 backpressure/lost:
//   - out_ready=0 with idx 3 presented; set_in=8'h08 -> pend_o=8'h08, lost_o=0.
//   - set_in=8'h08 again -> lost_o=8'h08; out_idx stays 3 throughout.
//  T5 set/clear race: pend_o=8'h10; clr_we=1, clr_mask=8'hFF, set_in=8'h10 same cycle -> pend_o=8'h10.
//  T6 full: set_in=8'hFF, out_ready=1 from ptr=0 -> indices 0..7 in order over 8 cycles; any_pend falls after the 8th load.

Source files
------------

// File: rtl/pending_flag_drain.sv
// Sticky pending-flag collector with round-robin, one-index-per-cycle drain
// over a valid/ready handshake. Per-bit state lives in pfd_flag_cell instances.

module pfd_flag_cell (
  input  logic clk,
  input  logic rst,
  input  logic i_set,
  input  logic i_clr,
  input  logic i_load,
  output logic o_pend,
  output logic o_lost
);
  logic r_pend;
  logic r_lost;

  // Set dominates both clear and load so a fresh event is never dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~i_clr & ~i_load) | i_set;
      if (i_set & r_pend & ~i_load) r_lost <= 1'b1;
      else if (i_clr)               r_lost <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_lost = r_lost;
endmodule

module pending_flag_drain #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set_in,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_mask,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pend_o,
  output logic [WIDTH-1:0] lost_o,
  output logic             any_pend
);
  logic [WIDTH-1:0] w_pend;
  logic [WIDTH-1:0] w_lost;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_load_bit;
  logic             w_free;
  logic             w_load;
  logic             w_found;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_ptr_nxt;

  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_ptr;

  assign w_clr = clr_we ? clr_mask : '0;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    pfd_flag_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .i_set  (set_in[g]),
      .i_clr  (w_clr[g]),
      .i_load (w_load_bit[g]),
      .o_pend (w_pend[g]),
      .o_lost (w_lost[g])
    );
  end

  // Round-robin search: first pending bit at ptr, ptr+1, ... wrapping at WIDTH.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      int               j;
      logic [IDX_W-1:0] j_idx;
      j = int'(r_ptr) + k;
      if (j >= WIDTH) j = j - WIDTH;
      j_idx = IDX_W'(j);
      if (!w_found && w_pend[j_idx]) begin
        w_found = 1'b1;
        w_sel   = j_idx;
      end
    end
  end

  assign w_free    = ~r_valid | out_ready;
  assign w_load    = w_free & w_found;
  assign w_ptr_nxt = (w_sel == IDX_W'(WIDTH - 1)) ? '0 : w_sel + IDX_W'(1);

  always_comb begin
    w_load_bit = '0;
    if (w_load) w_load_bit[w_sel] = 1'b1;
  end

  // Stage holds idx/valid/ptr while stalled; clears only when drained dry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_idx   <= w_sel;
      r_ptr   <= w_ptr_nxt;
    end else if (w_free) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign pend_o    = w_pend;
  assign lost_o    = w_lost;
  assign any_pend  = |w_pend;
endmodule

// File: tb/tb_pending_flag_drain.sv
// Directed bench for pending_flag_drain: reset, drain, round-robin,
// backpressure/lost, set/clear race and full-width drain.

module tb_pending_flag_drain;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] set_in = '0;
  logic       clr_we = 1'b0;
  logic [7:0] clr_mask = '0;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_ready = 1'b0;
  logic [7:0] pend_o;
  logic [7:0] lost_o;
  logic       any_pend;

  int n_chk = 0;
  int n_fail = 0;

  pending_flag_drain #(.WIDTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .set_in(set_in), .clr_we(clr_we), .clr_mask(clr_mask),
    .out_valid(out_valid), .out_idx(out_idx), .out_ready(out_ready),
    .pend_o(pend_o), .lost_o(lost_o), .any_pend(any_pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx);
    chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    if (v) chk({tag, "_idx"}, {29'b0, out_idx}, {29'b0, idx});
  endtask

  initial begin
    step(); step();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_idx",   {29'b0, out_idx},   32'd0);
    chk("rst_pend",  {24'b0, pend_o},    32'd0);
    chk("rst_lost",  {24'b0, lost_o},    32'd0);
    chk("rst_any",   {31'b0, any_pend},  32'd0);
    rst = 1'b0;

    // T2: drain 8'h24 -> 2 then 5
    out_ready = 1'b1;
    set_in = 8'h24;
    step(); set_in = '0;
    chk("t2_pend0", {24'b0, pend_o}, 32'h24);
    chk_out("t2_pre", 1'b0, 3'd0);
    step(); chk_out("t2_a", 1'b1, 3'd2);
    chk("t2_pend1", {24'b0, pend_o}, 32'h20);
    step(); chk_out("t2_b", 1'b1, 3'd5);
    chk("t2_pend2", {24'b0, pend_o}, 32'h00);
    step(); chk_out("t2_end", 1'b0, 3'd0);
    chk("t2_any", {31'b0, any_pend}, 32'd0);

    // T3: round-robin from ptr=6
    set_in = 8'h81;
    step(); set_in = '0;
    step(); chk_out("t3_a", 1'b1, 3'd7);
    step(); chk_out("t3_b", 1'b1, 3'd0);
    step(); chk_out("t3_end", 1'b0, 3'd0);

    // T4: backpressure, idx 3 presented, then lost
    out_ready = 1'b0;
    set_in = 8'h08;
    step(); set_in = '0;
    step(); chk_out("t4_load", 1'b1, 3'd3);
    chk("t4_pend0", {24'b0, pend_o}, 32'h00);
    set_in = 8'h08;
    step();
    chk("t4_pend1", {24'b0, pend_o}, 32'h08);
    chk("t4_lost1", {24'b0, lost_o}, 32'h00);
    chk_out("t4_hold1", 1'b1, 3'd3);
    step(); set_in = '0;
    chk("t4_lost2", {24'b0, lost_o}, 32'h08);
    chk_out("t4_hold2", 1'b1, 3'd3);
    clr_we = 1'b1; clr_mask = 8'h08;
    step(); clr_we = 1'b0; clr_mask = '0;
    chk("t4_clrp", {24'b0, pend_o}, 32'h00);
    chk("t4_clrl", {24'b0, lost_o}, 32'h00);
    chk_out("t4_hold3", 1'b1, 3'd3);

    // T5: set beats clear on the same bit
    set_in = 8'h10;
    step(); set_in = '0;
    chk("t5_pend0", {24'b0, pend_o}, 32'h10);
    clr_we = 1'b1; clr_mask = 8'hFF; set_in = 8'h10;
    step(); set_in = '0;
    chk("t5_pend1", {24'b0, pend_o}, 32'h10);
    chk("t5_lost1", {24'b0, lost_o}, 32'h10);
    step(); clr_we = 1'b0; clr_mask = '0;
    chk("t5_pend2", {24'b0, pend_o}, 32'h00);
    chk("t5_lost2", {24'b0, lost_o}, 32'h00);
    chk_out("t5_hold", 1'b1, 3'd3);

    // T1: async reset mid-cycle while out_valid=1 and pend nonzero
    set_in = 8'h02;
    step(); set_in = '0;
    chk("t1_pre_pend", {24'b0, pend_o}, 32'h02);
    #3 rst = 1'b1;
    #1;
    chk("t1_valid", {31'b0, out_valid}, 32'd0);
    chk("t1_idx",   {29'b0, out_idx},   32'd0);
    chk("t1_pend",  {24'b0, pend_o},    32'd0);
    chk("t1_lost",  {24'b0, lost_o},    32'd0);
    chk("t1_any",   {31'b0, any_pend},  32'd0);
    step(); rst = 1'b0;

    // T6: full drain from ptr=0
    out_ready = 1'b1;
    set_in = 8'hFF;
    step(); set_in = '0;
    chk("t6_pend", {24'b0, pend_o}, 32'hFF);
    for (int k = 0; k < 8; k++) begin
      step();
      chk_out($sformatf("t6_%0d", k), 1'b1, 3'(k));
      chk($sformatf("t6_any%0d", k), {31'b0, any_pend}, {31'b0, (k < 7)});
    end
    step(); chk_out("t6_end", 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
